// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per ena-high cycle, from the latched cipher key out to round NUM_ROUNDS.
// Optional macro KEYSBOX_TRIGGER_EN adds a scope trigger on the first key-schedule S-box round.
module aes_key_expand #(
  parameter int CYPHER_SIZE = 128,
  parameter int NUM_ROUNDS  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ena,
  input  logic                   start,
  input  logic [CYPHER_SIZE-1:0] cypher_key,
  input  logic [127:0]           plainText,
  output logic [127:0]           plain_out,
  output logic [127:0]           round_key,
  output logic [3:0]             round_idx,
  output logic                   rk_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   trigger
);

  generate
    if (CYPHER_SIZE != 128) begin : g_bad_size
      $error("aes_key_expand: only CYPHER_SIZE = 128 is supported");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
      $error("aes_key_expand: NUM_ROUNDS must be 1..10");
    end
  endgenerate

  // Forward S-box, byte 0x00 in the top byte so entry b sits at bit offset (255-b)*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  logic [127:0] plain_reg, plain_next;
  logic [3:0]   idx_reg, idx_next;
  logic         valid_reg, valid_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;

  logic [31:0]  w0, w1, w2, w3, rot_w3, sub_w3, n0, n1, n2, n3;
  logic [3:0]   idx_inc;

  assign idx_inc = idx_reg + 4'd1;
  assign w0      = key_reg[127:96];
  assign w1      = key_reg[95:64];
  assign w2      = key_reg[63:32];
  assign w3      = key_reg[31:0];
  assign rot_w3  = {w3[23:0], w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_w3[8*gi +: 8] = sbox(rot_w3[8*gi +: 8]);
    end
  endgenerate

  assign n0 = w0 ^ sub_w3 ^ {rcon(idx_inc), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // rk_valid/done are pulses: they drop on every edge unless set here.
  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    plain_next = plain_reg;
    idx_next   = idx_reg;
    valid_next = 1'b0;
    done_next  = 1'b0;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        // done_reg blocks a start issued in the same cycle as the final round key
        if (ena && start && !done_reg) begin
          key_next   = cypher_key;
          plain_next = plainText;
          idx_next   = 4'd0;
          valid_next = 1'b1;
          busy_next  = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (ena) begin
          key_next   = {n0, n1, n2, n3};
          idx_next   = idx_inc;
          valid_next = 1'b1;
          if (idx_inc == 4'(NUM_ROUNDS)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      plain_reg <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      plain_reg <= plain_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign round_key = key_reg;
  assign plain_out = plain_reg;
  assign round_idx = idx_reg;
  assign rk_valid  = valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

`ifdef KEYSBOX_TRIGGER_EN
  logic trigger_reg, trigger_next;

  // High exactly while round key 1 (the first S-box round) is presented.
  assign trigger_next = (state_reg == EXPAND) && ena && (idx_reg == 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trigger_reg <= 1'b0;
    else        trigger_reg <= trigger_next;
  end

  assign trigger = trigger_reg;
`else
  assign trigger = 1'b0;
`endif

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameter CYPHER_SIZE, default 128, cipher key width; only 128 is supported, and any other value SHALL fail elaboration.
REQ-002 Parameter NUM_ROUNDS, default 10, count of round keys generated after round key 0.
REQ-003 clk  input  1  single clock; every register is rising-edge.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 ena  input  1  advance enable; while low, all state SHALL hold.
REQ-006 start  input  1  request to expand the key currently on cypher_key.
REQ-007 cypher_key  input  CYPHER_SIZE  cipher key from the test-vector source.
REQ-008 plainText  input  128  plaintext from the test-vector source.
REQ-009 plain_out  output  128  plaintext latched at start, held until the next accepted start.
REQ-010 round_key  output  128  current round key; w0 = bits [127:96].
REQ-011 round_idx  output  4  index of round_key, 0..NUM_ROUNDS.
REQ-012 rk_valid  output  1  one-cycle qualifier for round_key/round_idx.
REQ-013 busy  output  1  high while expansion is in progress.
REQ-014 done  output  1  one-cycle pulse coincident with the final round key.
REQ-015 trigger  output  1  scope trigger (see Configuration).

Function
REQ-016 The FSM SHALL have the states IDLE and EXPAND; the reset state is IDLE.
REQ-017 In IDLE, a start with ena high SHALL be accepted: the block latches cypher_key and plainText, sets round_key to the key and round_idx to 0, pulses rk_valid, and moves to EXPAND at the next edge.
REQ-018 In EXPAND, each ena-high cycle SHALL compute the next key: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'. It SHALL then increment round_idx and pulse rk_valid.
REQ-019 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-020 SubWord SHALL apply the FIPS-197 S-box to each of the 4 bytes; RotWord is a left byte rotation.
REQ-021 Latency: with start accepted at edge T and ena held high, round key n SHALL be valid in the cycle after edge T+n. Round NUM_ROUNDS therefore appears after edge T+10, with done high in that same cycle, and the FSM returns to IDLE.
REQ-022 While ena is low, rk_valid and done SHALL be low, and round_key, round_idx and the FSM SHALL hold; expansion resumes when ena returns high.
REQ-023 start while busy SHALL be ignored; inputs are not sampled.
REQ-024 start on the same cycle as the final round SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-025 busy SHALL be high from the edge that accepts start through the cycle in which done is high, inclusive.
REQ-026 round_idx SHALL never exceed NUM_ROUNDS; there is no wrap-around.

Reset
REQ-027 Reset low SHALL immediately force: FSM to IDLE; round_key, plain_out, round_idx to 0; rk_valid, busy, done, trigger to 0.
REQ-028 Reset mid-expansion SHALL abort it with no done pulse; after release the block waits for a new start.

Configuration
REQ-029 Macro KEYSBOX_TRIGGER_EN: when defined, trigger SHALL pulse high for exactly the one cycle in which round_idx=1 is valid, marking the first key-schedule S-box computation for capture.
REQ-030 When KEYSBOX_TRIGGER_EN is not defined, trigger SHALL be tied to 0 and no trigger logic is generated.

Verification
REQ-031 Key 2b7e151628aed2a6abf7158809cf4f3c, start, ena high -> round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done, 11 rk_valid pulses total.
REQ-032 Key all zeros -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-033 ena low for 3 cycles after round 4 -> round_key/round_idx hold at 4 with rk_valid low; round 10 arrives 3 cycles later than with ena held high.
REQ-034 start pulsed at round 5 with a different key -> no effect; round 10 matches the original key, and plain_out is unchanged.
REQ-035 Reset asserted at round 6 -> all outputs are 0 immediately and there is no done pulse; a subsequent start produces round 0 equal to the new key.
REQ-036 With KEYSBOX_TRIGGER_EN defined -> a single trigger pulse coincides with round_idx=1; without the macro, trigger stays 0 throughout.
